ins_mem_responder: RTL and testbench

Instruction memory responder: the memory-side end of the datapath's instruction fetch interface. It accepts a byte address from the fetch stage through a request/ready handshake and returns the addressed 32-bit instruction word after a fixed, parameterised latency. It flags misaligned and out-of-range fetches, and it has a side load port for writing program words before or during execution. It sits between the datapath's instruction memory address/data ports and the program storage.

---
 rtl/ins_mem_responder.sv | 98 +++++++++
 tb/tb_ins_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_responder.sv
// Instruction memory responder: fixed-latency word fetch with error
// flagging for misaligned/out-of-range PCs and a side program-load port.
module ins_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                     ins_mem_clock_in,
    input  logic                     ins_mem_reset_in,
    input  logic [31:0]              ins_mem_addr_in,
    input  logic                     ins_mem_req_in,
    output logic                     ins_mem_ready_out,
    output logic [DATA_WIDTH-1:0]    ins_mem_data_out,
    output logic                     ins_mem_valid_out,
    output logic                     ins_mem_error_out,
    input  logic                     ins_mem_load_en_in,
    input  logic [$clog2(DEPTH)-1:0] ins_mem_load_addr_in,
    input  logic [DATA_WIDTH-1:0]    ins_mem_load_data_in
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [AW-1:0]         index;
    logic                  err;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic accept;
    logic addr_err;
    logic load_ok;

    assign ins_mem_ready_out = (state == IDLE) || (state == RESP);
    assign accept = ins_mem_req_in && ins_mem_ready_out;

    assign addr_err = (ins_mem_addr_in[1:0] != 2'b00)
                   || ({2'b00, ins_mem_addr_in[31:2]} >= 32'(DEPTH));

    assign load_ok = ins_mem_load_en_in && !ins_mem_reset_in
                  && (32'(ins_mem_load_addr_in) < 32'(DEPTH));

    // Storage is never cleared so a program survives a core reset.
    always_ff @(posedge ins_mem_clock_in) begin
        if (load_ok) begin
            mem[ins_mem_load_addr_in] <= ins_mem_load_data_in;
        end
    end

    always_ff @(posedge ins_mem_clock_in) begin
        if (ins_mem_reset_in) begin
            state             <= IDLE;
            cnt               <= '0;
            index             <= '0;
            err               <= 1'b0;
            ins_mem_data_out  <= '0;
            ins_mem_valid_out <= 1'b0;
            ins_mem_error_out <= 1'b0;
        end else begin
            ins_mem_valid_out <= 1'b0;
            if (accept) begin
                index <= ins_mem_addr_in[AW+1:2];
                err   <= addr_err;
                cnt   <= CW'(LATENCY - 1);
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state             <= RESP;
                        ins_mem_valid_out <= 1'b1;
                        ins_mem_error_out <= err;
                        ins_mem_data_out  <= err ? '0 : mem[index];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= accept ? WAIT : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_mem_responder.sv
// Bench for ins_mem_responder: scoreboarded fetches with latency,
// error, back-to-back, load-collision and reset-abort scenarios.
module tb_ins_mem_responder;

    localparam int DW  = 32;
    localparam int DEP = 256;
    localparam int LAT = 2;
    localparam int AW  = $clog2(DEP);

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   addr;
    logic          req;
    logic          ready;
    logic [DW-1:0] data;
    logic          valid;
    logic          error;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic          e;
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [DEP];

    always #5 clk = ~clk;

    ins_mem_responder #(
        .DATA_WIDTH(DW),
        .DEPTH(DEP),
        .LATENCY(LAT)
    ) dut (
        .ins_mem_clock_in    (clk),
        .ins_mem_reset_in    (rst),
        .ins_mem_addr_in     (addr),
        .ins_mem_req_in      (req),
        .ins_mem_ready_out   (ready),
        .ins_mem_data_out    (data),
        .ins_mem_valid_out   (valid),
        .ins_mem_error_out   (error),
        .ins_mem_load_en_in  (load_en),
        .ins_mem_load_addr_in(load_addr),
        .ins_mem_load_data_in(load_data)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor/scoreboard: sampled mid-cycle, inputs for the next edge are stable.
    always @(negedge clk) begin
        exp_t e;
        logic ae;
        cyc++;
        if (valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("resp_data", data, e.d);
                chk("resp_err", error, e.e);
                chk("resp_latency", cyc, e.c);
            end
        end
        if (rst) begin
            sb.delete();
        end else if (req && ready) begin
            ae = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEP);
            e.e = ae;
            e.d = ae ? '0 : model[addr[AW+1:2]];
            e.c = cyc + LAT + 1;
            sb.push_back(e);
        end
        if (load_en && !rst) begin
            model[load_addr] = load_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [DW-1:0] d);
        load_en = 1'b1;
        load_addr = AW'(idx);
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        req = 1'b1;
        addr = a;
        tick();
        req = 1'b0;
        addr = $urandom;
        repeat (LAT + 1) tick();
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        addr = '0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        tick();
        rst = 1'b0;
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_error", error, 0);
        chk("rst_ready", ready, 1);

        load(0, 32'h0000_0013);
        load(1, 32'hDEAD_BEEF);

        // Basic fetch with explicit ready/valid timing
        req = 1'b1;
        addr = 32'h4;
        tick();
        req = 1'b0;
        chk("wait1_ready", ready, 0);
        tick();
        chk("wait2_ready", ready, 0);
        chk("wait2_valid", valid, 0);
        tick();
        chk("resp_ready", ready, 1);
        chk("resp_valid", valid, 1);
        chk("resp_word", data, 32'hDEAD_BEEF);
        tick();
        chk("idle_ready", ready, 1);
        chk("idle_valid", valid, 0);
        chk("hold_data", data, 32'hDEAD_BEEF);

        fetch(32'h6);
        fetch(32'h400);
        fetch(32'h3FC + 32'h0);
        fetch(32'h0);

        // Back-to-back: req held high; WAIT-cycle address must be ignored
        req = 1'b1;
        addr = 32'h0;
        tick();
        addr = 32'h4;
        repeat (LAT) tick();
        chk("b2b_resp_ready", ready, 1);
        tick();
        req = 1'b0;
        repeat (LAT + 1) tick();

        // Load collides with RESP-entry read of the same word
        req = 1'b1;
        addr = 32'h4;
        tick();
        req = 1'b0;
        repeat (LAT - 1) tick();
        load_en = 1'b1;
        load_addr = AW'(1);
        load_data = 32'h1234_5678;
        tick();
        load_en = 1'b0;
        chk("coll_old", data, 32'hDEAD_BEEF);
        tick();
        fetch(32'h4);

        // Reset while in WAIT; a load on the reset edge is dropped
        req = 1'b1;
        addr = 32'h4;
        tick();
        req = 1'b0;
        rst = 1'b1;
        load_en = 1'b1;
        load_addr = '0;
        load_data = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        load_en = 1'b0;
        chk("abort_ready", ready, 1);
        for (int i = 0; i < LAT + 2; i++) begin
            chk("abort_no_valid", valid, 0);
            tick();
        end
        fetch(32'h4);
        fetch(32'h0);

        repeat (2) tick();
        chk("drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
